// File: rtl/my_arb8way16.sv
// Eight-requester arbiter feeding one 16-bit registered output with valid/ready.
// Round-robin (or fixed priority) winner select, one-hot ack, no overwrite of a pending word.
module my_arb8way16 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  output logic [7:0]  ack,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  grant_sel
);

  // state | meaning
  // EMPTY | r_valid=0, nothing held for the consumer
  // FULL  | r_valid=1, r_out waits for out_ready
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      r_state;
  logic        r_valid;
  logic [15:0] r_out;
  logic [2:0]  r_ptr;
  logic [2:0]  r_grant;

  logic        w_load;
  logic [2:0]  w_win;
  logic        w_found;
  logic [2:0]  w_idx;
  logic [15:0] w_out_next;

  always_comb begin
    w_win   = 3'd0;
    w_found = 1'b0;
    w_idx   = 3'd0;
    if (FIXED_PRIO) begin
      for (int i = 7; i >= 0; i--) begin
        if (req[i]) w_win = 3'(i);
      end
    end else begin
      // search wraps upward from the slot after the last winner
      for (int k = 1; k <= 8; k++) begin
        w_idx = r_ptr + 3'(k);
        if (!w_found && req[w_idx]) begin
          w_win   = w_idx;
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_out_next = 16'h0000;
    case (w_win)
      3'd0: w_out_next = in0;
      3'd1: w_out_next = in1;
      3'd2: w_out_next = in2;
      3'd3: w_out_next = in3;
      3'd4: w_out_next = in4;
      3'd5: w_out_next = in5;
      3'd6: w_out_next = in6;
      3'd7: w_out_next = in7;
      default: w_out_next = 16'h0000;
    endcase
  end

  assign w_load = (req != 8'h00) && (!r_valid || out_ready);
  // gated by rst_n so ack stays low for the whole reset window
  assign ack    = (w_load && rst_n) ? (8'b1 << w_win) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_out   <= 16'h0000;
      r_ptr   <= 3'd7;
      r_grant <= 3'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_load) begin
            r_state <= FULL;
            r_valid <= 1'b1;
            r_out   <= w_out_next;
            r_ptr   <= w_win;
            r_grant <= w_win;
          end
        end
        FULL: begin
          if (w_load) begin
            r_out   <= w_out_next;
            r_ptr   <= w_win;
            r_grant <= w_win;
          end else if (out_ready) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign grant_sel = r_grant;

endmodule

// File: tb/tb_my_arb8way16.sv
// Scoreboard bench for my_arb8way16: a reference model predicts ack per cycle and
// queues the expected word/index, which is popped and checked once the output register updates.
module tb_my_arb8way16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [15:0] in_w [8];
  logic        out_ready;
  logic [7:0]  ack, ack_fp;
  logic [15:0] out_d, out_fp;
  logic        out_valid, out_valid_fp;
  logic [2:0]  grant_sel, grant_fp;

  int total = 0;
  int bad   = 0;
  logic [18:0] sb_q [$];
  int   m_ptr;
  logic m_valid;
  bit   fp_chk;

  my_arb8way16 #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
    .in4(in_w[4]), .in5(in_w[5]), .in6(in_w[6]), .in7(in_w[7]),
    .ack(ack), .out(out_d), .out_valid(out_valid), .out_ready(out_ready),
    .grant_sel(grant_sel)
  );

  my_arb8way16 #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
    .in4(in_w[4]), .in5(in_w[5]), .in6(in_w[6]), .in7(in_w[7]),
    .ack(ack_fp), .out(out_fp), .out_valid(out_valid_fp), .out_ready(out_ready),
    .grant_sel(grant_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_win(input logic [7:0] r, input int p);
    logic [15:0] dbl;
    logic [7:0]  rot;
    dbl = {r, r};
    rot = 8'(dbl >> ((p + 1) % 8));
    for (int j = 0; j < 8; j++) if (rot[j]) return (p + 1 + j) % 8;
    return 0;
  endfunction

  task automatic step();
    logic        ld;
    int          w;
    logic [7:0]  ea;
    logic [18:0] e;
    #2;
    ld = (req != 8'h00) && (!m_valid || out_ready);
    w  = rr_win(req, m_ptr);
    ea = ld ? 8'(1 << w) : 8'h00;
    chk("ack", ack, ea);
    if (fp_chk) chk("fp_ack", ack_fp, 8'h01);
    if (ld) sb_q.push_back({w[2:0], in_w[w]});
    @(posedge clk); #1;
    if (ld) begin
      m_valid = 1'b1;
      m_ptr   = w;
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("out", out_d, e[15:0]);
        chk("grant_sel", grant_sel, e[18:16]);
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    chk("out_valid", out_valid, m_valid);
    if (fp_chk) chk("fp_out", out_fp, in_w[0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out_d, 16'h0000);
    chk("rst_grant", grant_sel, 0);
    chk("rst_ack", ack, 8'h00);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_ptr   = 7;
    m_valid = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b1; req = 8'hFF; out_ready = 1'b1; fp_chk = 1'b0;
    m_ptr = 7; m_valid = 1'b0;
    for (int i = 0; i < 8; i++) in_w[i] = 16'h1000 + 16'(i);
    #3;
    do_reset();

    // single request, first word after reset
    req = 8'h01; in_w[0] = 16'hBEEF;
    step();
    chk("beef_out", out_d, 16'hBEEF);
    req = 8'h00;
    step();

    // fairness walk with all eight requesting
    do_reset();
    for (int i = 0; i < 8; i++) in_w[i] = 16'h1000 + 16'(i);
    req = 8'hFF;
    for (int n = 0; n < 16; n++) begin
      step();
      chk("walk_out", out_d, 16'h1000 + 16'(n % 8));
    end

    // backpressure: FULL, out_ready low, nothing may be overwritten
    req = 8'h0C; out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("hold_out", out_d, 16'h1007);
      chk("hold_grant", grant_sel, 3'd7);
    end
    out_ready = 1'b1;
    step();
    chk("bp_grant2", grant_sel, 3'd2);
    req = 8'h08;
    step();
    chk("bp_grant3", grant_sel, 3'd3);
    req = 8'h00;
    step();

    // wrap-around from ptr=6
    do_reset();
    req = 8'h40; step();
    req = 8'h81; step();
    chk("wrap_grant7", grant_sel, 3'd7);
    req = 8'h01; step();
    chk("wrap_grant0", grant_sel, 3'd0);

    // fixed-priority instance keeps granting index 0
    req = 8'hFF; fp_chk = 1'b1;
    for (int n = 0; n < 4; n++) step();
    fp_chk = 1'b0;

    // reset while a word is held
    chk("pre_rst_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", out_d, 16'h0000);
    chk("mid_rst_ack", ack, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1; m_ptr = 7; m_valid = 1'b0; sb_q.delete();
    req = 8'hFF;
    step();
    chk("post_rst_grant", grant_sel, 3'd0);
    req = 8'h00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
